// File: rtl/calc_sequencer_if.sv
// Command/result bus for calc_sequencer: (op, data) in over valid/ready, (acc, aux, flags) out over valid/ready.
// Both directions follow the same rule: a transfer happens on a rising edge where valid and ready are both high.
interface calc_sequencer_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [7:0] cmd_data;
  logic       res_valid;
  logic       res_ready;
  logic [7:0] res_acc;
  logic [7:0] res_aux;
  logic [3:0] res_flags;

  modport master (
    output cmd_valid, cmd_op, cmd_data, res_ready,
    input  cmd_ready, res_valid, res_acc, res_aux, res_flags
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_data, res_ready,
    output cmd_ready, res_valid, res_acc, res_aux, res_flags
  );
endinterface

// File: rtl/calc_sequencer.sv
// Command-driven 8-bit accumulator; result valid EXEC_CYCLES+1 edges after accept, held until res_ready.
// cmd_ready only in IDLE (commands are never queued). Define CALC_UNDO_EN for the single-level UNDO register.
module calc_sequencer #(
  parameter int unsigned EXEC_CYCLES = 1,
  parameter logic [7:0]  CLR_VALUE   = 8'h00,
  parameter bit          STICKY_ERR  = 1'b0
) (
  input logic             i_clk,
  input logic             i_rst,
  calc_sequencer_if.slave io_bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_RESP
  } state_t;

  localparam logic [2:0] OP_LOAD = 3'd0;
  localparam logic [2:0] OP_ADD  = 3'd1;
  localparam logic [2:0] OP_SUB  = 3'd2;
  localparam logic [2:0] OP_MUL  = 3'd3;
  localparam logic [2:0] OP_DIV  = 3'd4;
  localparam logic [2:0] OP_CLR  = 3'd5;
`ifdef CALC_UNDO_EN
  localparam logic [2:0] OP_UNDO = 3'd6;
`endif
  localparam logic [3:0] LP_LAST = 4'(EXEC_CYCLES - 1);

  state_t     r_state;
  logic [3:0] r_cnt;
  logic [2:0] r_op;
  logic [7:0] r_data;
  logic [7:0] r_acc;
  logic       r_cmd_ready;
  logic       r_res_valid;
  logic [7:0] r_res_acc;
  logic [7:0] r_res_aux;
  logic [3:0] r_res_flags;
`ifdef CALC_UNDO_EN
  logic [7:0] r_prev_acc;
`endif

  logic [8:0]  w_sum;
  logic [8:0]  w_diff;
  logic [15:0] w_prod;
  logic [7:0]  w_acc;
  logic [7:0]  w_aux;
  logic        w_err;
  logic        w_dz;
  logic        w_carry;
  logic        w_upd_prev;
  logic        w_err_keep;
  logic [3:0]  w_flags;

  always_comb begin
    w_sum      = {1'b0, r_acc} + {1'b0, r_data};
    w_diff     = {1'b0, r_acc} - {1'b0, r_data};
    w_prod     = {8'd0, r_acc} * {8'd0, r_data};
    w_acc      = r_acc;
    w_aux      = 8'd0;
    w_err      = 1'b0;
    w_dz       = 1'b0;
    w_carry    = 1'b0;
    w_upd_prev = 1'b0;
    case (r_op)
      OP_LOAD: begin
        w_acc      = r_data;
        w_upd_prev = 1'b1;
      end
      OP_ADD: begin
        w_acc      = w_sum[7:0];
        w_carry    = w_sum[8];
        w_aux      = {7'd0, w_sum[8]};
        w_upd_prev = 1'b1;
      end
      OP_SUB: begin
        // bit 8 of the 9-bit difference is the borrow
        w_acc      = w_diff[7:0];
        w_carry    = w_diff[8];
        w_aux      = {7'd0, w_diff[8]};
        w_upd_prev = 1'b1;
      end
      OP_MUL: begin
        w_acc      = w_prod[7:0];
        w_aux      = w_prod[15:8];
        w_carry    = |w_prod[15:8];
        w_upd_prev = 1'b1;
      end
      OP_DIV: begin
        if (r_data == 8'd0) begin
          w_dz  = 1'b1;
          w_err = 1'b1;
        end else begin
          w_acc      = r_acc / r_data;
          w_aux      = r_acc % r_data;
          w_upd_prev = 1'b1;
        end
      end
      OP_CLR: begin
        w_acc      = CLR_VALUE;
        w_upd_prev = 1'b1;
      end
`ifdef CALC_UNDO_EN
      OP_UNDO: begin
        w_acc = r_prev_acc;
      end
`endif
      default: begin
        w_err = 1'b1;
      end
    endcase
  end

  // Sticky ERR survives every command except LOAD and CLR.
  assign w_err_keep = STICKY_ERR && r_res_flags[3] && (r_op != OP_LOAD) && (r_op != OP_CLR);
  assign w_flags    = {w_err | w_err_keep, w_dz, (w_acc == 8'd0), w_carry};

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= 4'd0;
      r_op        <= OP_LOAD;
      r_data      <= 8'd0;
      r_acc       <= CLR_VALUE;
      r_cmd_ready <= 1'b0;
      r_res_valid <= 1'b0;
      r_res_acc   <= CLR_VALUE;
      r_res_aux   <= 8'd0;
      r_res_flags <= 4'd0;
`ifdef CALC_UNDO_EN
      r_prev_acc  <= CLR_VALUE;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          r_cmd_ready <= 1'b1;
          if (io_bus.cmd_valid && r_cmd_ready) begin
            r_op        <= io_bus.cmd_op;
            r_data      <= io_bus.cmd_data;
            r_cnt       <= 4'd0;
            r_cmd_ready <= 1'b0;
            r_state     <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (r_cnt == LP_LAST) begin
            r_acc       <= w_acc;
            r_res_acc   <= w_acc;
            r_res_aux   <= w_aux;
            r_res_flags <= w_flags;
            r_res_valid <= 1'b1;
            r_state     <= S_RESP;
`ifdef CALC_UNDO_EN
            // UNDO swaps so a second UNDO restores the value just undone
            if (w_upd_prev || (r_op == OP_UNDO)) begin
              r_prev_acc <= r_acc;
            end
`endif
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        S_RESP: begin
          if (r_res_valid && io_bus.res_ready) begin
            r_res_valid <= 1'b0;
            r_cmd_ready <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_cmd_ready <= 1'b0;
          r_res_valid <= 1'b0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

`ifndef CALC_UNDO_EN
  logic w_unused_upd;
  assign w_unused_upd = w_upd_prev;
`endif

  assign io_bus.cmd_ready = r_cmd_ready;
  assign io_bus.res_valid = r_res_valid;
  assign io_bus.res_acc   = r_res_acc;
  assign io_bus.res_aux   = r_res_aux;
  assign io_bus.res_flags = r_res_flags;

  a_no_overlap: assert property (@(posedge i_clk) disable iff (i_rst)
    !(r_cmd_ready && r_res_valid));

  a_res_hold: assert property (@(posedge i_clk) disable iff (i_rst)
    (r_res_valid && !io_bus.res_ready) |=>
      (r_res_valid && $stable(r_res_acc) && $stable(r_res_aux) && $stable(r_res_flags)));

endmodule

// File: tb/tb_calc_sequencer.sv
// Directed, table-driven bench for calc_sequencer: a default instance and a STICKY_ERR=1 instance share one stimulus.
// Multi-cycle corners (backpressure hold, command spacing, reset during EXEC) are hand-written sequences.
module tb_calc_sequencer;

  localparam logic [2:0] OP_LOAD = 3'd0;
  localparam logic [2:0] OP_ADD  = 3'd1;
  localparam logic [2:0] OP_SUB  = 3'd2;
  localparam logic [2:0] OP_MUL  = 3'd3;
  localparam logic [2:0] OP_DIV  = 3'd4;
  localparam logic [2:0] OP_CLR  = 3'd5;
  localparam logic [2:0] OP_UNDO = 3'd6;
  localparam logic [2:0] OP_RSVD = 3'd7;
  localparam int         NVEC    = 27;

  typedef struct {
    logic [2:0] op;
    logic [7:0] data;
    logic [7:0] acc;
    logic [7:0] aux;
    logic [3:0] flags;
    logic [3:0] flags_s;
  } vec_t;

  logic       clk;
  logic       rst;
  logic       cmd_valid;
  logic [2:0] cmd_op;
  logic [7:0] cmd_data;
  logic       res_ready;

  int n_checks;
  int n_errors;

  calc_sequencer_if bus_a ();
  calc_sequencer_if bus_s ();

  assign bus_a.cmd_valid = cmd_valid;
  assign bus_a.cmd_op    = cmd_op;
  assign bus_a.cmd_data  = cmd_data;
  assign bus_a.res_ready = res_ready;
  assign bus_s.cmd_valid = cmd_valid;
  assign bus_s.cmd_op    = cmd_op;
  assign bus_s.cmd_data  = cmd_data;
  assign bus_s.res_ready = res_ready;

  calc_sequencer #(.EXEC_CYCLES(1), .CLR_VALUE(8'h00), .STICKY_ERR(1'b0)) u_dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .io_bus (bus_a)
  );

  calc_sequencer #(.EXEC_CYCLES(1), .CLR_VALUE(8'h00), .STICKY_ERR(1'b1)) u_dut_sticky (
    .i_clk  (clk),
    .i_rst  (rst),
    .io_bus (bus_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  // Called at a negedge with the DUT in IDLE; returns at a negedge after the result handshake.
  task automatic run_vec(input vec_t v, input int idx);
    int waits;
    int lat;
    cmd_valid = 1'b1;
    cmd_op    = v.op;
    cmd_data  = v.data;
    waits = 0;
    while (!bus_a.cmd_ready && waits < 20) begin
      @(negedge clk);
      waits++;
    end
    check("cmd_ready_wait", idx, 32'(bus_a.cmd_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    lat = 1;
    while (!bus_a.res_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("latency", idx, 32'(lat), 32'd2);
    check("acc", idx, 32'(bus_a.res_acc), 32'(v.acc));
    check("aux", idx, 32'(bus_a.res_aux), 32'(v.aux));
    check("flags", idx, 32'(bus_a.res_flags), 32'(v.flags));
    check("acc_sticky", idx, 32'(bus_s.res_acc), 32'(v.acc));
    check("flags_sticky", idx, 32'(bus_s.res_flags), 32'(v.flags_s));
    @(posedge clk);
    @(negedge clk);
  endtask

  vec_t vecs [NVEC];

  initial begin
    int n_acc;
    int n_resp;
    int hold_bad;
    int waits;
    logic [7:0] last_acc;
    vec_t v;

    vecs[0]  = '{OP_LOAD, 8'd200, 8'd200,  8'd0,   4'h0, 4'h0};
    vecs[1]  = '{OP_ADD,  8'd100, 8'd44,   8'd1,   4'h1, 4'h1};
    vecs[2]  = '{OP_ADD,  8'd0,   8'd44,   8'd0,   4'h0, 4'h0};
    vecs[3]  = '{OP_LOAD, 8'd5,   8'd5,    8'd0,   4'h0, 4'h0};
    vecs[4]  = '{OP_SUB,  8'd7,   8'd254,  8'd1,   4'h1, 4'h1};
    vecs[5]  = '{OP_LOAD, 8'd7,   8'd7,    8'd0,   4'h0, 4'h0};
    vecs[6]  = '{OP_SUB,  8'd7,   8'd0,    8'd0,   4'h2, 4'h2};
    vecs[7]  = '{OP_LOAD, 8'd20,  8'd20,   8'd0,   4'h0, 4'h0};
    vecs[8]  = '{OP_MUL,  8'd20,  8'h90,   8'h01,  4'h1, 4'h1};
    vecs[9]  = '{OP_LOAD, 8'd200, 8'd200,  8'd0,   4'h0, 4'h0};
    vecs[10] = '{OP_DIV,  8'd7,   8'd28,   8'd4,   4'h0, 4'h0};
    vecs[11] = '{OP_LOAD, 8'd9,   8'd9,    8'd0,   4'h0, 4'h0};
    vecs[12] = '{OP_DIV,  8'd0,   8'd9,    8'd0,   4'hC, 4'hC};
    vecs[13] = '{OP_ADD,  8'd1,   8'd10,   8'd0,   4'h0, 4'h8};
    vecs[14] = '{OP_MUL,  8'd0,   8'd0,    8'd0,   4'h2, 4'hA};
    vecs[15] = '{OP_CLR,  8'd99,  8'd0,    8'd0,   4'h2, 4'h2};
    vecs[16] = '{OP_LOAD, 8'd255, 8'd255,  8'd0,   4'h0, 4'h0};
    vecs[17] = '{OP_ADD,  8'd1,   8'd0,    8'd1,   4'h3, 4'h3};
    vecs[18] = '{OP_LOAD, 8'd16,  8'd16,   8'd0,   4'h0, 4'h0};
    vecs[19] = '{OP_MUL,  8'd16,  8'd0,    8'd1,   4'h3, 4'h3};
    vecs[20] = '{OP_RSVD, 8'd55,  8'd0,    8'd0,   4'hA, 4'hA};
    vecs[21] = '{OP_LOAD, 8'd3,   8'd3,    8'd0,   4'h0, 4'h0};
    vecs[22] = '{OP_ADD,  8'd4,   8'd7,    8'd0,   4'h0, 4'h0};
`ifdef CALC_UNDO_EN
    vecs[23] = '{OP_UNDO, 8'd0,   8'd3,    8'd0,   4'h0, 4'h0};
    vecs[24] = '{OP_UNDO, 8'd0,   8'd7,    8'd0,   4'h0, 4'h0};
`else
    vecs[23] = '{OP_UNDO, 8'd0,   8'd7,    8'd0,   4'h8, 4'h8};
    vecs[24] = '{OP_UNDO, 8'd0,   8'd7,    8'd0,   4'h8, 4'h8};
`endif
    vecs[25] = '{OP_LOAD, 8'd1,   8'd1,    8'd0,   4'h0, 4'h0};
    vecs[26] = '{OP_DIV,  8'd255, 8'd0,    8'd1,   4'h2, 4'h2};

    n_checks  = 0;
    n_errors  = 0;
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = 3'd0;
    cmd_data  = 8'd0;
    res_ready = 1'b1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_cmd_ready", 0, 32'(bus_a.cmd_ready), 32'd0);
    check("rst_res_valid", 0, 32'(bus_a.res_valid), 32'd0);
    check("rst_res_acc", 0, 32'(bus_a.res_acc), 32'h00);
    check("rst_res_aux", 0, 32'(bus_a.res_aux), 32'h00);
    check("rst_res_flags", 0, 32'(bus_a.res_flags), 32'h0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_cmd_ready", 0, 32'(bus_a.cmd_ready), 32'd1);

    for (int i = 0; i < NVEC; i++) begin
      run_vec(vecs[i], i);
    end

    // Spacing: with cmd_valid and res_ready held high, one accept every 3 edges.
    v = '{OP_LOAD, 8'd0, 8'd0, 8'd0, 4'h2, 4'h2};
    run_vec(v, 100);
    cmd_valid = 1'b1;
    cmd_op    = OP_ADD;
    cmd_data  = 8'd1;
    n_acc = 0;
    for (int i = 0; i < 12; i++) begin
      if (bus_a.cmd_ready) n_acc++;
      @(posedge clk);
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    check("spacing_accepts", 101, 32'(n_acc), 32'd4);
    check("spacing_acc", 101, 32'(bus_a.res_acc), 32'd4);

    // Backpressure: result held for 10 cycles while the next command waits unqueued.
    @(negedge clk);
    res_ready = 1'b0;
    cmd_valid = 1'b1;
    cmd_op    = OP_LOAD;
    cmd_data  = 8'd10;
    waits = 0;
    while (!bus_a.cmd_ready && waits < 20) begin
      @(negedge clk);
      waits++;
    end
    @(posedge clk);
    @(negedge clk);
    cmd_op   = OP_ADD;
    cmd_data = 8'd5;
    waits = 0;
    while (!bus_a.res_valid && waits < 40) begin
      @(negedge clk);
      waits++;
    end
    check("bp_res_valid", 102, 32'(bus_a.res_valid), 32'd1);
    hold_bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus_a.res_valid !== 1'b1 || bus_a.res_acc !== 8'd10 || bus_a.res_aux !== 8'd0 ||
          bus_a.res_flags !== 4'h0 || bus_a.cmd_ready !== 1'b0 || bus_s.cmd_ready !== 1'b0)
        hold_bad++;
    end
    check("bp_hold_stable", 102, 32'(hold_bad), 32'd0);
    res_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("bp_release_ready", 103, 32'(bus_a.cmd_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    n_resp = 0;
    last_acc = 8'hxx;
    for (int i = 0; i < 20; i++) begin
      if (bus_a.res_valid) begin
        n_resp++;
        last_acc = bus_a.res_acc;
      end
      @(negedge clk);
    end
    check("bp_resp_count", 104, 32'(n_resp), 32'd1);
    check("bp_resp_acc", 104, 32'(last_acc), 32'd15);

    // Reset while the command sits in EXEC: it is dropped and no response appears.
    cmd_valid = 1'b1;
    cmd_op    = OP_LOAD;
    cmd_data  = 8'd77;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    rst       = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("exec_rst_cmd_ready", 105, 32'(bus_a.cmd_ready), 32'd0);
    check("exec_rst_res_valid", 105, 32'(bus_a.res_valid), 32'd0);
    check("exec_rst_res_acc", 105, 32'(bus_a.res_acc), 32'h00);
    check("exec_rst_res_flags", 105, 32'(bus_a.res_flags), 32'h0);
    rst = 1'b0;
    n_resp = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus_a.res_valid || bus_s.res_valid) n_resp++;
    end
    check("exec_rst_no_resp", 106, 32'(n_resp), 32'd0);
    v = '{OP_ADD, 8'd5, 8'd5, 8'd0, 4'h0, 4'h0};
    run_vec(v, 107);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", n_errors, n_checks);
    $fatal(1);
  end

endmodule
